// File: rtl/stack_unit.sv
// stack_unit: on-chip hardware stack of DEPTH entries, each WIDTH bits wide.
//
// Supports push, pop and a same-cycle replace (push+pop). It also provides:
//   - a registered top-of-stack;
//   - a combinational peek port;
//   - full/empty status;
//   - sticky overflow/underflow flags;
//   - a high-water mark.
//
// Ports:
//   clk        clock, all state updates on the rising edge
//   rst        synchronous active-low reset
//   push/pop   operation request; {push,pop}=11 replaces the top entry
//   din        data to push or replace
//   top        registered top-of-stack, 0 when empty
//   count      number of valid entries, 0..DEPTH
//   empty/full combinational decode of count
//   rd_idx     peek depth, 0 = top
//   rd_data    entry at depth rd_idx (pre-edge state), 0 if out of range
//   overflow   sticky: push attempted while full
//   underflow  sticky: pop (or replace) attempted while empty
//   clr_err    clear both sticky flags; a same-cycle new error still sets
//   hwm        maximum count reached since reset
module stack_unit #(
    parameter int  WIDTH = 16,
    parameter int  DEPTH = 16,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] top,
    output logic [CW-1:0]    count,
    output logic             empty,
    output logic             full,
    input  logic [AW-1:0]    rd_idx,
    output logic [WIDTH-1:0] rd_data,
    output logic             overflow,
    output logic             underflow,
    input  logic             clr_err,
    output logic [CW-1:0]    hwm
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] top_q, top_d;
    logic             ovf_q, ovf_d, unf_q, unf_d;
    logic [CW-1:0]    hwm_q, hwm_d;

    logic             we_d;
    logic [CW-1:0]    wa_d;
    logic             new_ovf, new_unf;

    // Index arithmetic is done at count width; only the low AW bits address
    // the array, and they are only used when the full value is in range.
    logic [CW-1:0]    below_top;
    logic [CW-1:0]    rd_ext, pk_idx;

    assign empty     = (count_q == '0);
    assign full      = (count_q == CW'(DEPTH));
    assign count     = count_q;
    assign top       = top_q;
    assign overflow  = ovf_q;
    assign underflow = unf_q;
    assign hwm       = hwm_q;

    assign below_top = count_q - CW'(2);
    assign rd_ext    = CW'(rd_idx);
    assign pk_idx    = count_q - CW'(1) - rd_ext;
    assign rd_data   = (rd_ext < count_q) ? mem_q[pk_idx[AW-1:0]] : '0;

    always_comb begin
        count_d = count_q;
        top_d   = top_q;
        we_d    = 1'b0;
        wa_d    = '0;
        new_ovf = 1'b0;
        new_unf = 1'b0;
        unique case ({push, pop})
            2'b10: begin
                if (full) begin
                    new_ovf = 1'b1;
                end else begin
                    we_d    = 1'b1;
                    wa_d    = count_q;
                    count_d = count_q + CW'(1);
                    top_d   = din;
                end
            end
            2'b01: begin
                if (empty) begin
                    new_unf = 1'b1;
                end else begin
                    count_d = count_q - CW'(1);
                    // The new top is the entry just below the old top,
                    // read from the array because top_q only holds one entry.
                    top_d   = (count_q >= CW'(2)) ? mem_q[below_top[AW-1:0]] : '0;
                end
            end
            2'b11: begin
                // Replace never changes count, so it cannot overflow even
                // when the stack is full.
                if (empty) begin
                    new_unf = 1'b1;
                end else begin
                    we_d  = 1'b1;
                    wa_d  = count_q - CW'(1);
                    top_d = din;
                end
            end
            default: ;
        endcase
        // A new error beats clr_err; a flag that did not error this cycle
        // is cleared by clr_err.
        ovf_d = new_ovf | (ovf_q & ~clr_err);
        unf_d = new_unf | (unf_q & ~clr_err);
        hwm_d = (count_d > hwm_q) ? count_d : hwm_q;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            count_q <= '0;
            top_q   <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
            hwm_q   <= '0;
        end else begin
            count_q <= count_d;
            top_q   <= top_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
            hwm_q   <= hwm_d;
        end
    end

    // The storage array is not reset; reset only suppresses writes.
    always_ff @(posedge clk) begin
        if (rst && we_d) begin
            mem_q[wa_d[AW-1:0]] <= din;
        end
    end

endmodule

// File: doc/stack_unit.md
Name: stack_unit

Overview:
- Parametrised hardware stack; successor to the fixed 16-bit stack pointer block.
- Holds the stack contents on-chip, not just a pointer.
- Provides push/pop with same-cycle replace, a registered top-of-stack, an indexed peek port, full/empty status, sticky overflow/underflow errors and a high-water mark.
- Sits beside the CPU datapath; used for return addresses and saved registers.

Parameters:
WIDTH  16  entry width in bits (>=1)
DEPTH  16  number of entries (>=2)
AW     $clog2(DEPTH)  peek index width (derived, do not override)
CW     $clog2(DEPTH+1)  count width (derived, do not override)

Ports:
clk        in   1      clock, all state on rising edge
rst        in   1      reset
push       in   1      push din this cycle
pop        in   1      pop top this cycle
din        in   WIDTH  data to push/replace
top        out  WIDTH  registered top-of-stack, 0 when empty
count      out  CW     number of valid entries, 0..DEPTH
empty      out  1      count==0 (combinational from count)
full       out  1      count==DEPTH (combinational from count)
rd_idx     in   AW     peek depth, 0 = top
rd_data    out  WIDTH  combinational entry at depth rd_idx
overflow   out  1      sticky: push attempted while full
underflow  out  1      sticky: pop attempted while empty
clr_err    in   1      clear overflow/underflow
hwm        out  CW     maximum count reached since reset

Behaviour:
Clock and reset:
- One clock: clk.
- Reset is synchronous and active-low: rst=0 at a rising edge resets the block.
- On reset: count=0, top=0, overflow=0, underflow=0, hwm=0.
- Storage array is not reset.
- Reset overrides all other inputs in the same cycle.

Storage and data:
- Entry i (0 = bottom) is held at mem[i].
- The logical top is mem[count-1].
- A consumer samples top in the same cycle it asserts pop; top is valid before the pop, not after.

Operations, decoded each cycle from {push, pop} (all updates visible the cycle after the edge):
- 00: no change.
- push only, not full: mem[count]<=din; count+1; top<=din.
- push only, full: no write; count and top unchanged; overflow<=1.
- pop only, not empty: count-1; top<=mem[count-2], or 0 if the new count is 0.
- pop only, empty: no change; underflow<=1.
- push+pop, not empty (replace): mem[count-1]<=din; count unchanged; top<=din. This applies when full too, with no overflow.
- push+pop, empty: no write; count stays 0; underflow<=1.

Errors:
- overflow and underflow are sticky until clr_err=1 or reset.
- clr_err in the same cycle as a new error: the error wins and the flag stays 1.
- The other, non-erroring flag is cleared in that cycle.

High-water mark:
- hwm<=max(hwm, next count) every cycle.
- hwm is only cleared by reset.

Peek:
- rd_data = mem[count-1-rd_idx] when rd_idx < count, else 0.
- rd_data is combinational and reflects current (pre-edge) state.
- rd_idx=0 equals top.

Arithmetic:
- count never wraps; it saturates logically via the full/empty guards above.
- Index arithmetic is done in CW bits, with no truncation for DEPTH a power of two.

Reset mid-operation:
- Any push/pop asserted with rst=0 is discarded.
- The stack is empty on the following cycle.

Test Plan:
1. WIDTH=16, DEPTH=4; reset, push 0x1111, 0x2222, 0x3333 on consecutive cycles -> count=3, top=0x3333, hwm=3; rd_idx=2 -> rd_data=0x1111; rd_idx=3 -> rd_data=0.
2. Push 0x4444 (count=4, full=1), push 0x5555 -> no change, top=0x4444, overflow=1. Then pop four times -> tops seen 0x4444, 0x3333, 0x2222, 0x1111; afterwards empty=1, top=0, overflow still 1, hwm=4.
3. Empty stack: pop -> underflow=1, count=0. push+pop with din=0xAAAA -> underflow stays 1, count=0. Assert clr_err alone -> both flags 0.
4. With count=2 and top=0x2222, push+pop din=0xBEEF -> count=2, top=0xBEEF, rd_idx=1 -> 0x1111. On a full stack, push+pop -> replace, overflow stays 0.
5. Full stack: push and clr_err together -> overflow=1 after the edge. With underflow=1, clr_err plus a push on a non-full stack -> underflow=0.
6. count=3; drive rst=0 with push=1 for one cycle -> next cycle count=0, top=0, hwm=0, flags 0. Then push 0x7777 -> count=1, top=0x7777.
